// File: rtl/mem_fill_seq_if.sv
// Control and memory-port bundle between mem_fill_seq, its controller and the memory array.
// master = the sequencer; slave = the controller plus array side.
interface mem_fill_seq_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
);
  logic              start;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  fill_val;
  logic              busy;
  logic              done;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              mem_re;
  logic [WIDTH-1:0]  mem_rdata;
  logic              err;
  logic [ADDR_W-1:0] err_addr;

  modport master (
    input  start, mode, fill_val, mem_rdata,
    output busy, done, mem_we, mem_addr, mem_wdata, mem_re, err, err_addr
  );

  modport slave (
    output start, mode, fill_val, mem_rdata,
    input  busy, done, mem_we, mem_addr, mem_wdata, mem_re, err, err_addr
  );
endinterface

// File: rtl/mem_fill_seq.sv
// Fills a DEPTH x WIDTH register memory with a generated pattern, one word per cycle.
// Define MEM_FILL_SEQ_CHECK_EN to build the readback pass (CHECK/FLUSH, mem_re, err, err_addr).
//
// state | meaning
// IDLE  | waiting for start, array port released
// FILL  | writing pattern(addr) to addresses 0..DEPTH-1
// CHECK | reading addresses 0..DEPTH-1 back
// FLUSH | last read data returning, final compare
module mem_fill_seq #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_fill_seq_if.master bus
);

  typedef enum logic [1:0] {IDLE, FILL, CHECK, FLUSH} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        mode_q;
  logic [1:0]        mode_nxt;
  logic [WIDTH-1:0]  val_q;
  logic [WIDTH-1:0]  val_nxt;
  logic              busy_q;
  logic              busy_nxt;
  logic              done_q;
  logic              done_nxt;
  logic              we_q;
  logic              we_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nxt;
  logic [WIDTH-1:0]  wdata_q;
  logic [WIDTH-1:0]  wdata_nxt;

`ifdef MEM_FILL_SEQ_CHECK_EN
  logic              re_q;
  logic              re_nxt;
  logic              err_q;
  logic              err_nxt;
  logic [ADDR_W-1:0] err_addr_q;
  logic [ADDR_W-1:0] err_addr_nxt;
  logic              chk_vld_q;
  logic [ADDR_W-1:0] chk_addr_q;
`endif

  function automatic logic [WIDTH-1:0] pattern(
    input logic [1:0]        m,
    input logic [WIDTH-1:0]  v,
    input logic [ADDR_W-1:0] a
  );
    logic [WIDTH-1:0] p;
    case (m)
      2'd0:    p = v;
      2'd1:    p = WIDTH'(a);
      2'd2:    p = {{(WIDTH-1){1'b0}}, 1'b1} << (32'(a) % WIDTH);
      default: p = a[0] ? ~v : v;
    endcase
    return p;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    val_nxt   = val_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    we_nxt    = 1'b0;
    addr_nxt  = addr_q;
    wdata_nxt = '0;
`ifdef MEM_FILL_SEQ_CHECK_EN
    re_nxt       = 1'b0;
    err_nxt      = err_q;
    err_addr_nxt = err_addr_q;
    // read data in this cycle belongs to the address issued last cycle; first mismatch sticks
    if (chk_vld_q && !err_q && (bus.mem_rdata != pattern(mode_q, val_q, chk_addr_q))) begin
      err_nxt      = 1'b1;
      err_addr_nxt = chk_addr_q;
    end
`endif

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = FILL;
          mode_nxt  = bus.mode;
          val_nxt   = bus.fill_val;
          busy_nxt  = 1'b1;
          we_nxt    = 1'b1;
          addr_nxt  = '0;
          wdata_nxt = pattern(bus.mode, bus.fill_val, '0);
`ifdef MEM_FILL_SEQ_CHECK_EN
          err_nxt      = 1'b0;
          err_addr_nxt = '0;
`endif
        end
      end

      FILL: begin
        if (addr_q == LAST_ADDR) begin
          addr_nxt = '0;
`ifdef MEM_FILL_SEQ_CHECK_EN
          state_nxt = CHECK;
          re_nxt    = 1'b1;
`else
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
`endif
        end else begin
          we_nxt    = 1'b1;
          addr_nxt  = addr_q + 1'b1;
          wdata_nxt = pattern(mode_q, val_q, addr_q + 1'b1);
        end
      end

`ifdef MEM_FILL_SEQ_CHECK_EN
      CHECK: begin
        if (addr_q == LAST_ADDR) begin
          state_nxt = FLUSH;
          addr_nxt  = '0;
        end else begin
          re_nxt   = 1'b1;
          addr_nxt = addr_q + 1'b1;
        end
      end

      FLUSH: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
      end
`endif

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= '0;
      val_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      mode_q  <= mode_nxt;
      val_q   <= val_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      we_q    <= we_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
    end
  end

`ifdef MEM_FILL_SEQ_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_q       <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      chk_vld_q  <= 1'b0;
      chk_addr_q <= '0;
    end else begin
      re_q       <= re_nxt;
      err_q      <= err_nxt;
      err_addr_q <= err_addr_nxt;
      chk_vld_q  <= re_q;
      chk_addr_q <= addr_q;
    end
  end

  assign bus.mem_re   = re_q;
  assign bus.err      = err_q;
  assign bus.err_addr = err_addr_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^bus.mem_rdata;

  assign bus.mem_re   = 1'b0;
  assign bus.err      = 1'b0;
  assign bus.err_addr = '0;
`endif

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_fill_seq.sv
// Randomized bench for mem_fill_seq: per-cycle traces compared against a timing/pattern reference
// built from the fill/check rules, with a behavioural memory array that can corrupt read data.
`timescale 1ns/1ps
module tb_mem_fill_seq;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
`ifdef MEM_FILL_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int DONE_K = CHK ? 2*DEPTH + 2 : DEPTH + 1;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              we;
    logic              re;
    logic              err;
    logic [ADDR_W-1:0] err_addr;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t tr [0:63];

  mem_fill_seq_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();
  mem_fill_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] corrupt [DEPTH];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr] ^ corrupt[bus.mem_addr];
  end

  function automatic logic [WIDTH-1:0] ref_pat(input int m, input logic [WIDTH-1:0] v, input int a);
    case (m)
      0:       return v;
      1:       return WIDTH'(a % 256);
      2:       return WIDTH'(1) << (a % WIDTH);
      default: return (a % 2 == 0) ? v : ~v;
    endcase
  endfunction

  function automatic int first_bad();
    if (!CHK) return -1;
    for (int a = 0; a < DEPTH; a++)
      if (corrupt[a] != '0) return a;
    return -1;
  endfunction

  // expected observation k cycles after the start-accept edge
  function automatic obs_t exp_at(input int k, input int m, input logic [WIDTH-1:0] v, input int fb);
    obs_t e;
    e      = '0;
    e.busy = (k >= 1) && (k < DONE_K);
    e.done = (k == DONE_K);
    e.we   = (k >= 1) && (k <= DEPTH);
    e.re   = CHK && (k > DEPTH) && (k <= 2*DEPTH);
    if (e.we) begin
      e.addr  = ADDR_W'(k - 1);
      e.wdata = ref_pat(m, v, k - 1);
    end
    if (e.re) e.addr = ADDR_W'(k - DEPTH - 1);
    if (fb >= 0 && k >= DEPTH + 3 + fb) begin
      e.err      = 1'b1;
      e.err_addr = ADDR_W'(fb);
    end
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.busy     = bus.busy;
    o.done     = bus.done;
    o.we       = bus.mem_we;
    o.re       = bus.mem_re;
    o.err      = bus.err;
    o.err_addr = bus.err_addr;
    o.addr     = bus.mem_addr;
    o.wdata    = bus.mem_wdata;
    return o;
  endfunction

  function automatic logic [4+ADDR_W:0] ctl(input obs_t o);
    return {o.busy, o.done, o.we, o.re, o.err, o.err_addr};
  endfunction

  task automatic clear_corrupt();
    for (int a = 0; a < DEPTH; a++) corrupt[a] = '0;
  endtask

  task automatic launch(input logic [1:0] m, input logic [WIDTH-1:0] v);
    bus.start    = 1'b1;
    bus.mode     = m;
    bus.fill_val = v;
  endtask

  // records n cycles; inputs are scrambled once busy, and start is re-pulsed at cycle 'poke'
  task automatic capture(input int n, input int poke);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      tr[k] = sample();
      if (k == 1) begin
        bus.start    = 1'b0;
        bus.mode     = 2'($urandom);
        bus.fill_val = WIDTH'($urandom);
      end
      if (k == poke) begin
        bus.start    = 1'b1;
        bus.mode     = 2'($urandom);
        bus.fill_val = WIDTH'($urandom);
      end
      if (k == poke + 1) bus.start = 1'b0;
    end
  endtask

  task automatic test_reset();
    obs_t o;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.mode     = '0;
    bus.fill_val = '0;
    clear_corrupt();
    repeat (3) @(negedge clk);
    o = sample();
    n_tests++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL reset_held got %h want 0", o);
    end
    rst = 1'b0;
    @(negedge clk);
    o = sample();
    n_tests++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL reset_idle got %h want 0", o);
    end
  endtask

  task automatic test_fill_patterns();
    int modes [6] = '{0, 2, 3, 1, 0, 3};
    obs_t ex;
    logic [WIDTH-1:0] v;
    clear_corrupt();
    for (int i = 0; i < 6; i++) begin
      v = (i == 0) ? 8'hA5 : (i == 2) ? 8'h0F : WIDTH'($urandom);
      launch(2'(modes[i]), v);
      capture(DONE_K + 1, 0);
      for (int k = 1; k <= DONE_K + 1; k++) begin
        ex = exp_at(k, modes[i], v, -1);
        n_tests++;
        if (ctl(tr[k]) !== ctl(ex)) begin
          n_fail++;
          $display("FAIL fill_ctl mode=%0d k=%0d got %b want %b", modes[i], k, ctl(tr[k]), ctl(ex));
        end
        if (ex.we || ex.re) begin
          n_tests++;
          if (tr[k].addr !== ex.addr || (ex.we && tr[k].wdata !== ex.wdata)) begin
            n_fail++;
            $display("FAIL fill_data mode=%0d k=%0d got addr %0d data %h want addr %0d data %h",
                     modes[i], k, tr[k].addr, tr[k].wdata, ex.addr, ex.wdata);
          end
        end
      end
      for (int a = 0; a < DEPTH; a++) begin
        n_tests++;
        if (mem[a] !== ref_pat(modes[i], v, a)) begin
          n_fail++;
          $display("FAIL fill_mem mode=%0d addr=%0d got %h want %h", modes[i], a, mem[a], ref_pat(modes[i], v, a));
        end
      end
    end
  endtask

  task automatic test_check();
    obs_t ex;
    logic [WIDTH-1:0] v;
    int fb;
    int r;
    for (int c = 0; c < 5; c++) begin
      clear_corrupt();
      case (c)
        1: begin corrupt[5] = 8'h40; corrupt[9] = 8'h01; end
        2: corrupt[0] = 8'h80;
        3: corrupt[DEPTH-1] = 8'h02;
        4: begin
          r = $urandom_range(0, DEPTH - 2);
          corrupt[r] = WIDTH'($urandom_range(1, 255));
          corrupt[$urandom_range(r + 1, DEPTH - 1)] = WIDTH'($urandom_range(1, 255));
        end
        default: ;
      endcase
      fb = first_bad();
      v  = WIDTH'($urandom);
      launch(2'd1, v);
      capture(DONE_K + 1, 0);
      for (int k = 1; k <= DONE_K + 1; k++) begin
        ex = exp_at(k, 1, v, fb);
        n_tests++;
        if (ctl(tr[k]) !== ctl(ex)) begin
          n_fail++;
          $display("FAIL check_ctl case=%0d k=%0d got %b want %b", c, k, ctl(tr[k]), ctl(ex));
        end
        if (ex.we || ex.re) begin
          n_tests++;
          if (tr[k].addr !== ex.addr || (ex.we && tr[k].wdata !== ex.wdata)) begin
            n_fail++;
            $display("FAIL check_data case=%0d k=%0d got addr %0d data %h want addr %0d data %h",
                     c, k, tr[k].addr, tr[k].wdata, ex.addr, ex.wdata);
          end
        end
      end
    end
    clear_corrupt();
  endtask

  task automatic test_busy_start();
    obs_t ex;
    logic [WIDTH-1:0] v;
    int pokes [2] = '{5, DONE_K - 2};
    for (int i = 0; i < 2; i++) begin
      v = WIDTH'($urandom);
      launch(2'd2, v);
      capture(DONE_K + 1, pokes[i]);
      for (int k = 1; k <= DONE_K + 1; k++) begin
        ex = exp_at(k, 2, v, -1);
        n_tests++;
        if (ctl(tr[k]) !== ctl(ex)) begin
          n_fail++;
          $display("FAIL busy_start_ctl poke=%0d k=%0d got %b want %b", pokes[i], k, ctl(tr[k]), ctl(ex));
        end
        if (ex.we || ex.re) begin
          n_tests++;
          if (tr[k].addr !== ex.addr || (ex.we && tr[k].wdata !== ex.wdata)) begin
            n_fail++;
            $display("FAIL busy_start_data poke=%0d k=%0d got addr %0d data %h want addr %0d data %h",
                     pokes[i], k, tr[k].addr, tr[k].wdata, ex.addr, ex.wdata);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t ex;
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    int fba;
    clear_corrupt();
    corrupt[3] = 8'h01;
    fba = first_bad();
    va  = WIDTH'($urandom);
    launch(2'd3, va);
    capture(DONE_K, 0);
    for (int k = 1; k <= DONE_K; k++) begin
      ex = exp_at(k, 3, va, fba);
      n_tests++;
      if (ctl(tr[k]) !== ctl(ex) || ((ex.we || ex.re) && tr[k].addr !== ex.addr)
          || (ex.we && tr[k].wdata !== ex.wdata)) begin
        n_fail++;
        $display("FAIL b2b_first k=%0d got %h want %h", k, tr[k], ex);
      end
    end
    // start asserted in the done cycle of the first run
    clear_corrupt();
    vb = WIDTH'($urandom);
    launch(2'd2, vb);
    capture(DONE_K + 1, 0);
    for (int k = 1; k <= DONE_K + 1; k++) begin
      ex = exp_at(k, 2, vb, -1);
      n_tests++;
      if (ctl(tr[k]) !== ctl(ex) || ((ex.we || ex.re) && tr[k].addr !== ex.addr)
          || (ex.we && tr[k].wdata !== ex.wdata)) begin
        n_fail++;
        $display("FAIL b2b_second k=%0d got %h want %h", k, tr[k], ex);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    obs_t ex;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] want;
    clear_corrupt();
    launch(2'd0, 8'h3C);
    capture(DONE_K + 1, 0);
    v = WIDTH'($urandom);
    launch(2'd2, v);
    capture(6, 0);
    for (int k = 1; k <= 6; k++) begin
      ex = exp_at(k, 2, v, -1);
      n_tests++;
      if (ctl(tr[k]) !== ctl(ex) || tr[k].addr !== ex.addr || tr[k].wdata !== ex.wdata) begin
        n_fail++;
        $display("FAIL rst_mid_pre k=%0d got %h want %h", k, tr[k], ex);
      end
    end
    @(negedge clk);
    o = sample();
    n_tests++;
    if (o.we !== 1'b1 || o.busy !== 1'b1 || o.addr !== ADDR_W'(6)) begin
      n_fail++;
      $display("FAIL rst_mid_k7 got we=%b busy=%b addr=%0d want we=1 busy=1 addr=6", o.we, o.busy, o.addr);
    end
    #1 rst = 1'b1;
    #1 o = sample();
    n_tests++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL rst_async got %h want 0", o);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.mem_we !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_hold cycle=%0d got done=%b busy=%b we=%b want 0 0 0", k, bus.done, bus.busy, bus.mem_we);
      end
    end
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      want = (a < 6) ? ref_pat(2, v, a) : 8'h3C;
      n_tests++;
      if (mem[a] !== want) begin
        n_fail++;
        $display("FAIL rst_mem addr=%0d got %h want %h", a, mem[a], want);
      end
    end
    v = WIDTH'($urandom);
    launch(2'd1, v);
    capture(DONE_K + 1, 0);
    for (int k = 1; k <= DONE_K + 1; k++) begin
      ex = exp_at(k, 1, v, -1);
      n_tests++;
      if (ctl(tr[k]) !== ctl(ex) || ((ex.we || ex.re) && tr[k].addr !== ex.addr)
          || (ex.we && tr[k].wdata !== ex.wdata)) begin
        n_fail++;
        $display("FAIL rst_restart k=%0d got %h want %h", k, tr[k], ex);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_patterns();
    test_check();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
